// File: rtl/arb_pkg.sv
// Shared defaults and FSM state type for the request arbiter.
package arb_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int ID_W_DEF  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/arb_prio_pick.sv
// Combinational picker: first set request found scanning upward from start, with wrap.
module arb_prio_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  id
);

  logic [ID_W-1:0] idx;

  // Scan from the far end back toward start so the nearest hit is written last.
  always_comb begin
    onehot = '0;
    id     = '0;
    idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(start) + k) % N_REQ);
      if (req[idx]) begin
        onehot      = '0;
        onehot[idx] = 1'b1;
        id          = idx;
      end
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// Single-owner resource arbiter with hold timeout and a turnaround cycle between grants.
// ARB_ROUND_ROBIN_EN selects rotating priority; otherwise the highest index wins.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int HC_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e       state, state_n;
  logic [N_REQ-1:0] gnt_n;
  logic [ID_W-1:0]  gnt_id_n;
  logic [HC_W-1:0]  hold_cnt, hold_n;
  logic             timeout_n;
  logic             hold_expired, owner_req, release_now;

  logic [N_REQ-1:0] pick_req, pick_oh, win_oh;
  logic [ID_W-1:0]  pick_start, pick_id, win_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr, rr_ptr_n;

  assign pick_req   = req;
  assign pick_start = (rr_ptr == ID_W'(N_REQ - 1)) ? '0 : rr_ptr + ID_W'(1);
  assign win_oh     = pick_oh;
  assign win_id     = pick_id;
`else
  // Reverse the vector so a low-first scan from 0 yields highest-index priority.
  always_comb begin
    pick_req = '0;
    win_oh   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick_req[i] = req[N_REQ-1-i];
      win_oh[i]   = pick_oh[N_REQ-1-i];
    end
  end
  assign pick_start = '0;
  assign win_id     = ID_W'(N_REQ - 1) - pick_id;
`endif

  arb_prio_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req    (pick_req),
    .start  (pick_start),
    .onehot (pick_oh),
    .id     (pick_id)
  );

  assign owner_req    = req[gnt_id];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign release_now  = done || !owner_req || hold_expired;
  assign gnt_valid    = |gnt;

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    hold_n    = hold_cnt;
    timeout_n = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_n  = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_n  = OWNED;
          gnt_n    = win_oh;
          gnt_id_n = win_id;
          hold_n   = '0;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_n = win_id;
`endif
        end
      end
      OWNED: begin
        if (release_now) begin
          state_n   = IDLE;
          gnt_n     = '0;
          gnt_id_n  = '0;
          // A coinciding done or request drop makes this an ordinary release.
          timeout_n = hold_expired && !done && owner_req;
        end else if (hold_cnt != '1) begin
          hold_n = hold_cnt + HC_W'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        gnt_n    = '0;
        gnt_id_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      hold_cnt <= hold_n;
      timeout  <= timeout_n;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr   <= rr_ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed and randomized checks of req_arbiter against a cycle-level ownership model.
module tb_req_arbiter;
  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: current owner (-1 = free), cycles held so far, last winner, timeout flag.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 0;
  int m_to    = 0;

  req_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] q, input int last);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++)
      if (q[(last + k) % 4]) return (last + k) % 4;
`else
    for (int i = 3; i >= 0; i--)
      if (q[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [3:0] q, input logic d);
    if (r) begin
      m_owner = -1; m_held = 0; m_last = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      if (q != 0) begin
        m_owner = pick(q, m_last);
        m_last  = m_owner;
        m_held  = 1;
      end
    end else if (d || !q[m_owner]) begin
      m_owner = -1; m_to = 0;
    end else if (MAXH != 0 && m_held == MAXH) begin
      m_owner = -1; m_to = 1;
    end else begin
      m_held++; m_to = 0;
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, compare 1 time unit later.
  task automatic step(input logic r, input logic [3:0] q, input logic d);
    logic [3:0] eg;
    reset = r; req = q; done = d;
    @(posedge clk);
    model_edge(r, q, d);
    #1;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] rq;
    logic [3:0] order [5];
    order[0] = 4'b0010; order[1] = 4'b0100; order[2] = 4'b1000;
    order[3] = 4'b0001; order[4] = 4'b0010;
    @(negedge clk);

    // Reset held two cycles with all requests up.
    step(1, 4'b1111, 0);
    step(1, 4'b1111, 0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    step(0, 4'b1111, 0);
    chk("first_grant_valid", 32'(gnt_valid), 32'd1);

`ifdef ARB_ROUND_ROBIN_EN
    // Rotating order 1,2,3,0,1 with an idle cycle between grants.
    chk("rr_g0", 32'(gnt), 32'(order[0]));
    for (int i = 1; i < 5; i++) begin
      step(0, 4'b1111, 1);
      chk("rr_idle", 32'(gnt_valid), 32'd0);
      step(0, 4'b1111, 0);
      chk("rr_order", 32'(gnt), 32'(order[i]));
    end
    step(0, 4'b0110, 1);
`else
    chk("fix_first", 32'(gnt), 32'b1000);
    step(0, 4'b0110, 1);
    chk("fix_idle0", 32'(gnt), 32'd0);
    step(0, 4'b0110, 0);
    chk("fix_hi", 32'(gnt), 32'b0100);
    chk("fix_hi_id", 32'(gnt_id), 32'd2);
    step(0, 4'b0010, 1);
    chk("fix_idle1", 32'(gnt), 32'd0);
    step(0, 4'b0010, 0);
    chk("fix_lo", 32'(gnt), 32'b0010);
`endif

    // Hold timeout with a lone requester 0.
    step(0, 4'b0001, 1);
    step(0, 4'b0001, 0);
    chk("to_g1", 32'(gnt), 32'b0001);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b0001, 0);
      chk("to_held", 32'(gnt), 32'b0001);
    end
    step(0, 4'b0001, 0);
    chk("to_drop", 32'(gnt), 32'd0);
    chk("to_pulse", 32'(timeout), 32'd1);
    step(0, 4'b0001, 0);
    chk("to_regrant", 32'(gnt), 32'b0001);
    chk("to_pulse_end", 32'(timeout), 32'd0);

    // Owner 3 drops its request in its second grant cycle while requester 0 waits.
    step(0, 4'b1000, 1);
    step(0, 4'b1000, 0);
    chk("drop_g3", 32'(gnt), 32'b1000);
    step(0, 4'b1001, 0);
    step(0, 4'b0001, 0);
    chk("drop_clear", 32'(gnt), 32'd0);
    chk("drop_no_to", 32'(timeout), 32'd0);
    step(0, 4'b0001, 0);
    chk("drop_g0", 32'(gnt), 32'b0001);

    // Reset while requester 3 owns the resource.
    step(0, 4'b1000, 1);
    step(0, 4'b1000, 0);
    chk("mid_g3", 32'(gnt), 32'b1000);
    step(1, 4'b1000, 0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_id", 32'(gnt_id), 32'd0);
    chk("mid_rst_valid", 32'(gnt_valid), 32'd0);
    step(0, 4'b1111, 0);
`ifdef ARB_ROUND_ROBIN_EN
    chk("mid_rr_ptr0", 32'(gnt), 32'b0010);
`else
    chk("mid_fix", 32'(gnt), 32'b1000);
`endif

    // Randomized traffic; requests tend to persist so holds reach the timeout.
    rq = 4'b1111;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) rq = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) < 2), rq, ($urandom_range(0, 99) < 15));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
